hm2_avmm_reg_bridge: RTL and testbench
======================================

// Module: hm2_avmm_reg_bridge
// PURPOSE
//  Avalon-MM slave to HM2 register-bus bridge; sits directly upstream of the GPIO
//  address decoder/register block and the hm2 core register path.
//  Converts single Avalon word transactions into held-address write/read strobes.
//  Times the decoder's multi-cycle read path, returns captured busdata_out as
//  avs_readdata with readdatavalid. Stalls the HPS master via waitrequest meanwhile.
// PARAMETERS
//  AddrWidth    16  byte-address width of the register space; word address = AddrWidth-2 bits
//  BusWidth     32  data width
//  WritePulse   2   cycles write_reg held high per write (1..15)
//  GapCycles    2   cycles write_reg/read_reg forced low after every transaction (1..15)
//  ReadLatency  4   cycles from read_reg rise to busdata_out sample (1..15)
// PORTS
//  reg_clk            in   1              register clock; all logic on rising edge
//  reset_reg          in   1              synchronous reset, active-high
//  avs_address        in   AddrWidth-2    Avalon word address
//  avs_read           in   1              Avalon read request
//  avs_write          in   1              Avalon write request
//  avs_writedata      in   BusWidth       Avalon write data
//  avs_readdata       out  BusWidth       read return data
//  avs_readdatavalid  out  1              one-cycle read-return strobe
//  avs_waitrequest    out  1              stall; request accepted only when low
//  busaddress         out  AddrWidth-2    word address to decoder, held between transactions
//  busdata_in         out  BusWidth       write data to decoder, held between transactions
//  write_reg          out  1              write strobe to decoder
//  read_reg           out  1              read strobe to decoder
//  busdata_out        in   BusWidth       read data from decoder
//  proto_err          out  1              sticky: read and write presented together
// BEHAVIOUR
//  - All outputs registered. Reset values: avs_readdata=0, avs_readdatavalid=0,
//    avs_waitrequest=1, busaddress=0, busdata_in=0, write_reg=0, read_reg=0,
//    proto_err=0. State=IDLE. 4-bit down-counter cnt=0.
//  - FSM states: IDLE, WR, RD, RET, GAP.
//  - avs_waitrequest=0 only in IDLE; 1 in every other state and during reset.
//  - Cycle T, IDLE with avs_write: accept. At T+1:
//    busaddress<=avs_address, busdata_in<=avs_writedata, write_reg=1, ->WR.
//    write_reg stays high for exactly WritePulse cycles, T+1..T+WritePulse.
//    Then ->GAP.
//  - Cycle T, IDLE with avs_read only: accept. At T+1: busaddress<=avs_address,
//    read_reg=1 for exactly one cycle, ->RD. busdata_out is sampled at edge
//    T+1+ReadLatency. ->RET: avs_readdata=sample, avs_readdatavalid=1 for the
//    single cycle T+2+ReadLatency; readdata holds that value afterwards. Then ->GAP.
//  - GAP: write_reg=read_reg=0 for GapCycles cycles, then ->IDLE. This guarantees
//    a fresh rising edge for the decoder's edge-triggered write capture.
//  - avs_read and avs_write both high in IDLE: perform the write only, set
//    proto_err=1. proto_err clears only on reset_reg.
//  - busaddress/busdata_in never change outside an accept cycle.
//    Back-to-back requests: minimum spacing is WritePulse+GapCycles+1 cycles for
//    writes and ReadLatency+GapCycles+2 cycles for reads.
//  - Requests while waitrequest=1 are not sampled. The master holds them until
//    accepted.
//  - reset_reg mid-transaction: next edge forces reset values and IDLE.
//    No readdatavalid is ever issued for an aborted read. Strobes drop immediately.
//  - cnt loads parameter-1 on state entry and decrements. State exits at cnt==0.
//    No wrap: cnt never decrements below 0.
// TESTING
//  1 Reset then write addr 0x0440 (byte 0x1100), data 0x00FFFFFF -> write_reg high
//    2 cycles, busaddress=0x0440, busdata_in=0x00FFFFFF held, waitrequest low
//    5 cycles after accept.
//  2 Read addr 0x0448, busdata_out driven 0x03020100 -> read_reg high 1 cycle,
//    readdatavalid 1 cycle at T+6, readdata=0x03020100.
//  3 Write then read issued back-to-back by master -> read stalled by waitrequest
//    until IDLE; two distinct strobes; GAP of 2 low cycles between them.
//  4 read+write asserted together, addr 0x0441 -> write performed only,
//    proto_err=1 and stays 1 until reset.
//  5 reset_reg asserted on cycle T+3 of a read -> no readdatavalid,
//    all outputs at reset values next edge, next read completes normally.
//  6 ReadLatency=1, WritePulse=1, GapCycles=1 -> read returns at T+3,
//    write pulse width 1, spacing per formulas.

Source files
------------

// File: rtl/hm2_avmm_reg_bridge_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : hm2_avmm_reg_bridge_if
//  Purpose  : Signal bundle between an Avalon-MM master, the HM2 register
//             bridge and the downstream HM2 register decoder.
//  Modports : slave  - bridge view (Avalon requests and decoder read data in,
//                      Avalon responses and decoder strobes/address/data out)
//             master - environment view (the mirror of slave)
//  Signals  : avs_address[ADDR_WIDTH-3:0]  Avalon word address
//             avs_read / avs_write         Avalon requests
//             avs_writedata                Avalon write data
//             avs_readdata                 read return data
//             avs_readdatavalid            one-cycle read-return strobe
//             avs_waitrequest              stall, request taken only when low
//             busaddress / busdata_in      held address / write data to decoder
//             write_reg / read_reg         decoder strobes
//             busdata_out                  read data from decoder
//             proto_err                    sticky read+write collision flag
//  Revision : 1.0  initial release
// ============================================================================
interface hm2_avmm_reg_bridge_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int BUS_WIDTH  = 32
);
    logic [ADDR_WIDTH-3:0] avs_address;
    logic                  avs_read;
    logic                  avs_write;
    logic [BUS_WIDTH-1:0]  avs_writedata;
    logic [BUS_WIDTH-1:0]  avs_readdata;
    logic                  avs_readdatavalid;
    logic                  avs_waitrequest;
    logic [ADDR_WIDTH-3:0] busaddress;
    logic [BUS_WIDTH-1:0]  busdata_in;
    logic                  write_reg;
    logic                  read_reg;
    logic [BUS_WIDTH-1:0]  busdata_out;
    logic                  proto_err;

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata, busdata_out,
        output avs_readdata, avs_readdatavalid, avs_waitrequest,
               busaddress, busdata_in, write_reg, read_reg, proto_err
    );

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata, busdata_out,
        input  avs_readdata, avs_readdatavalid, avs_waitrequest,
               busaddress, busdata_in, write_reg, read_reg, proto_err
    );
endinterface
`default_nettype wire

// File: rtl/hm2_avmm_reg_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : hm2_avmm_reg_bridge
//  Purpose  : Avalon-MM slave to HM2 register-bus bridge. Turns single Avalon
//             word accesses into held-address write/read strobes, times the
//             decoder's multi-cycle read path and returns the captured data
//             with avs_readdatavalid, stalling the master with waitrequest.
//  Ports    : reg_clk    - register clock, rising edge
//             reset_reg  - synchronous reset, active high
//             io_bus     - hm2_avmm_reg_bridge_if.slave (Avalon + decoder side)
//  Params   : ADDR_WIDTH   byte-address width (word address is 2 bits less)
//             BUS_WIDTH    data width
//             WRITE_PULSE  cycles write_reg is held high (1..15)
//             GAP_CYCLES   cycles both strobes are low after a transaction (1..15)
//             READ_LATENCY decoder read-path length in cycles (1..15)
//  Revision : 1.0  initial release
// ============================================================================
module hm2_avmm_reg_bridge #(
    parameter int ADDR_WIDTH   = 16,
    parameter int BUS_WIDTH    = 32,
    parameter int WRITE_PULSE  = 2,
    parameter int GAP_CYCLES   = 2,
    parameter int READ_LATENCY = 4
) (
    input  wire logic             reg_clk,
    input  wire logic             reset_reg,
    hm2_avmm_reg_bridge_if.slave  io_bus
);

    localparam logic [3:0] c_WR_LOAD  = 4'(WRITE_PULSE - 1);
    localparam logic [3:0] c_GAP_LOAD = 4'(GAP_CYCLES - 1);
    localparam logic [3:0] c_RD_LOAD  = 4'(READ_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WR   = 3'd1,
        S_RD   = 3'd2,
        S_RET  = 3'd3,
        S_GAP  = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [3:0]            r_cnt;
    logic [3:0]            w_cnt_next;
    logic                  w_cnt_zero;
    logic                  w_accept;

    logic [BUS_WIDTH-1:0]  r_readdata;
    logic                  r_readdatavalid;
    logic                  r_waitrequest;
    logic [ADDR_WIDTH-3:0] r_busaddress;
    logic [BUS_WIDTH-1:0]  r_busdata_in;
    logic                  r_write_reg;
    logic                  r_read_reg;
    logic                  r_proto_err;

    // State register and dwell counter.
    always_ff @(posedge reg_clk) begin
        if (reset_reg) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state logic. A request is only taken when the registered
    // waitrequest the master sees is low; this also covers the first cycle
    // after reset, where the state is IDLE but waitrequest is still high.
    always_comb begin
        w_accept     = (r_state == S_IDLE) && !r_waitrequest &&
                       (io_bus.avs_read || io_bus.avs_write);
        w_cnt_zero   = (r_cnt == 4'd0);
        w_next_state = r_state;
        w_cnt_next   = w_cnt_zero ? 4'd0 : (r_cnt - 4'd1);
        case (r_state)
            S_IDLE: begin
                w_cnt_next = 4'd0;
                if (w_accept) begin
                    // A collided read+write is serviced as a write.
                    if (io_bus.avs_write) begin
                        w_next_state = S_WR;
                        w_cnt_next   = c_WR_LOAD;
                    end else begin
                        w_next_state = S_RD;
                        w_cnt_next   = c_RD_LOAD;
                    end
                end
            end
            S_WR: begin
                if (w_cnt_zero) begin
                    w_next_state = S_GAP;
                    w_cnt_next   = c_GAP_LOAD;
                end
            end
            S_RD: begin
                if (w_cnt_zero) begin
                    w_next_state = S_RET;
                    w_cnt_next   = 4'd0;
                end
            end
            // RET is the sampling cycle: busdata_out is captured on its
            // closing edge so data and valid appear together in the first GAP cycle.
            S_RET: begin
                w_next_state = S_GAP;
                w_cnt_next   = c_GAP_LOAD;
            end
            S_GAP: begin
                if (w_cnt_zero) begin
                    w_next_state = S_IDLE;
                    w_cnt_next   = 4'd0;
                end
            end
            default: begin
                w_next_state = S_IDLE;
                w_cnt_next   = 4'd0;
            end
        endcase
    end

    // Registered outputs, derived from the state being entered so that every
    // strobe lines up exactly with its state.
    always_ff @(posedge reg_clk) begin
        if (reset_reg) begin
            r_readdata      <= '0;
            r_readdatavalid <= 1'b0;
            r_waitrequest   <= 1'b1;
            r_busaddress    <= '0;
            r_busdata_in    <= '0;
            r_write_reg     <= 1'b0;
            r_read_reg      <= 1'b0;
            r_proto_err     <= 1'b0;
        end else begin
            r_waitrequest   <= (w_next_state != S_IDLE);
            r_write_reg     <= (w_next_state == S_WR);
            r_read_reg      <= w_accept && !io_bus.avs_write;
            r_readdatavalid <= (r_state == S_RET);
            if (r_state == S_RET) begin
                r_readdata <= io_bus.busdata_out;
            end
            // Address and write data only move on an accept, so the decoder
            // sees them stable across the whole strobe and gap.
            if (w_accept) begin
                r_busaddress <= io_bus.avs_address;
                if (io_bus.avs_write) begin
                    r_busdata_in <= io_bus.avs_writedata;
                    if (io_bus.avs_read) begin
                        r_proto_err <= 1'b1;
                    end
                end
            end
        end
    end

    assign io_bus.avs_readdata      = r_readdata;
    assign io_bus.avs_readdatavalid = r_readdatavalid;
    assign io_bus.avs_waitrequest   = r_waitrequest;
    assign io_bus.busaddress        = r_busaddress;
    assign io_bus.busdata_in        = r_busdata_in;
    assign io_bus.write_reg         = r_write_reg;
    assign io_bus.read_reg          = r_read_reg;
    assign io_bus.proto_err         = r_proto_err;

endmodule
`default_nettype wire

// File: tb/tb_hm2_avmm_reg_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_hm2_avmm_reg_bridge
//  Purpose  : Self-checking bench for hm2_avmm_reg_bridge. Two instances:
//             A with default timing (2/2/4), B with minimum timing (1/1/1).
//             Directed vectors from a table plus hand-written sequences for
//             back-to-back stalling and mid-read reset.
//  Revision : 1.0  initial release
// ============================================================================
module tb_hm2_avmm_reg_bridge;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        r_sel;      // 0: instance A, 1: instance B
    logic        r_read;
    logic        r_write;
    logic [13:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_bdo;

    hm2_avmm_reg_bridge_if #(.ADDR_WIDTH(16), .BUS_WIDTH(32)) u_if_a ();
    hm2_avmm_reg_bridge_if #(.ADDR_WIDTH(16), .BUS_WIDTH(32)) u_if_b ();

    assign u_if_a.avs_address   = r_addr;
    assign u_if_a.avs_writedata = r_wdata;
    assign u_if_a.busdata_out   = r_bdo;
    assign u_if_a.avs_read      = r_read  & ~r_sel;
    assign u_if_a.avs_write     = r_write & ~r_sel;
    assign u_if_b.avs_address   = r_addr;
    assign u_if_b.avs_writedata = r_wdata;
    assign u_if_b.busdata_out   = r_bdo;
    assign u_if_b.avs_read      = r_read  & r_sel;
    assign u_if_b.avs_write     = r_write & r_sel;

    hm2_avmm_reg_bridge #(
        .ADDR_WIDTH(16), .BUS_WIDTH(32),
        .WRITE_PULSE(2), .GAP_CYCLES(2), .READ_LATENCY(4)
    ) u_dut_a (
        .reg_clk   (clk),
        .reset_reg (rst),
        .io_bus    (u_if_a)
    );

    hm2_avmm_reg_bridge #(
        .ADDR_WIDTH(16), .BUS_WIDTH(32),
        .WRITE_PULSE(1), .GAP_CYCLES(1), .READ_LATENCY(1)
    ) u_dut_b (
        .reg_clk   (clk),
        .reset_reg (rst),
        .io_bus    (u_if_b)
    );

    // Outputs of the selected instance.
    wire logic        w_wq    = r_sel ? u_if_b.avs_waitrequest   : u_if_a.avs_waitrequest;
    wire logic        w_wr    = r_sel ? u_if_b.write_reg         : u_if_a.write_reg;
    wire logic        w_rd    = r_sel ? u_if_b.read_reg          : u_if_a.read_reg;
    wire logic        w_rv    = r_sel ? u_if_b.avs_readdatavalid : u_if_a.avs_readdatavalid;
    wire logic [31:0] w_rdata = r_sel ? u_if_b.avs_readdata      : u_if_a.avs_readdata;
    wire logic [13:0] w_baddr = r_sel ? u_if_b.busaddress        : u_if_a.busaddress;
    wire logic [31:0] w_bdi   = r_sel ? u_if_b.busdata_in        : u_if_a.busdata_in;
    wire logic        w_perr  = r_sel ? u_if_b.proto_err         : u_if_a.proto_err;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Offsets are cycles after the accept cycle (accept cycle = 0).
    typedef struct {
        bit          dut;
        bit          wr;
        bit          rd;
        logic [13:0] addr;
        logic [31:0] wdata;
        logic [31:0] bdo;
        int          wr_w;     // write_reg high cycles
        int          rd_w;     // read_reg high cycles
        int          rv_at;    // readdatavalid offset, 0 = none
        logic [31:0] rdata;
        int          idle_at;  // first offset with waitrequest low
        logic [31:0] bdi;
        bit          proto;
    } vec_t;

    vec_t vecs[8];
    vec_t vfinal;

    task automatic run_vec(input string tag, input vec_t v);
        int          waitn;
        int          wr_w, wr_first, rd_w, rv_n, rv_at, idle_at, addr_chg;
        logic [31:0] rdata;
        logic [13:0] addr0;
        wr_w = 0; wr_first = -1; rd_w = 0; rv_n = 0; rv_at = 0;
        idle_at = -1; addr_chg = 0; rdata = '0; addr0 = '0;
        r_sel = v.dut;
        r_bdo = v.bdo;
        @(negedge clk);
        r_write = v.wr; r_read = v.rd; r_addr = v.addr; r_wdata = v.wdata;
        waitn = 0;
        while (w_wq === 1'b1 && waitn < 50) begin
            @(negedge clk);
            waitn++;
        end
        chk({tag, " accept_timeout"}, 32'(waitn >= 50), 32'd0);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (w_wr) begin
                wr_w++;
                if (wr_first < 0) wr_first = k;
            end
            if (w_rd) rd_w++;
            if (w_rv) begin
                rv_n++;
                rv_at = k;
                rdata = w_rdata;
            end
            if (k == 1) begin
                addr0   = w_baddr;
                r_write = 1'b0;
                r_read  = 1'b0;
            end else if (w_baddr !== addr0) begin
                addr_chg++;
            end
            if (!w_wq && idle_at < 0) begin
                idle_at = k;
                break;
            end
        end
        chk({tag, " wr_width"}, 32'(wr_w), 32'(v.wr_w));
        chk({tag, " wr_first"}, 32'(wr_first), v.wr ? 32'd1 : 32'hFFFF_FFFF);
        chk({tag, " rd_width"}, 32'(rd_w), 32'(v.rd_w));
        chk({tag, " rv_count"}, 32'(rv_n), 32'(v.rv_at > 0));
        chk({tag, " rv_at"}, 32'(rv_at), 32'(v.rv_at));
        if (v.rv_at > 0) begin
            chk({tag, " readdata"}, rdata, v.rdata);
            chk({tag, " readdata_hold"}, w_rdata, v.rdata);
        end
        chk({tag, " idle_at"}, 32'(idle_at), 32'(v.idle_at));
        chk({tag, " busaddress"}, 32'(w_baddr), 32'(v.addr));
        chk({tag, " addr_changes"}, 32'(addr_chg), 32'd0);
        chk({tag, " busdata_in"}, w_bdi, v.bdi);
        chk({tag, " proto_err"}, 32'(w_perr), 32'(v.proto));
    endtask

    task automatic chk_reset_a(input string tag);
        chk({tag, " waitrequest"}, 32'(u_if_a.avs_waitrequest), 32'd1);
        chk({tag, " readdatavalid"}, 32'(u_if_a.avs_readdatavalid), 32'd0);
        chk({tag, " readdata"}, u_if_a.avs_readdata, 32'd0);
        chk({tag, " busaddress"}, 32'(u_if_a.busaddress), 32'd0);
        chk({tag, " busdata_in"}, u_if_a.busdata_in, 32'd0);
        chk({tag, " write_reg"}, 32'(u_if_a.write_reg), 32'd0);
        chk({tag, " read_reg"}, 32'(u_if_a.read_reg), 32'd0);
        chk({tag, " proto_err"}, 32'(u_if_a.proto_err), 32'd0);
    endtask

    initial begin
        int          acc, last_wr, first_rd, rv_at, waitn, rv_n;
        logic [31:0] rdata;

        rst = 1'b1; r_sel = 1'b0; r_read = 1'b0; r_write = 1'b0;
        r_addr = '0; r_wdata = '0; r_bdo = '0;
        repeat (3) @(negedge clk);
        chk_reset_a("rst");
        chk("rst b_waitrequest", 32'(u_if_b.avs_waitrequest), 32'd1);
        rst = 1'b0;

        //            dut  wr    rd    addr      wdata         bdo           wr rd rv rdata        idle bdi           proto
        vecs[0] = '{1'b0, 1'b1, 1'b0, 14'h0440, 32'h00FF_FFFF, 32'h0,        2, 0, 0, 32'h0,        5, 32'h00FF_FFFF, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 14'h0448, 32'h0,         32'h0302_0100, 0, 1, 6, 32'h0302_0100, 8, 32'h00FF_FFFF, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 14'h0123, 32'hDEAD_BEEF, 32'h0,        2, 0, 0, 32'h0,        5, 32'hDEAD_BEEF, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 14'h3FFF, 32'h0,         32'hFFFF_FFFF, 0, 1, 6, 32'hFFFF_FFFF, 8, 32'hDEAD_BEEF, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 14'h0441, 32'hA5A5_5A5A, 32'h0000_0077, 2, 0, 0, 32'h0,        5, 32'hA5A5_5A5A, 1'b1};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 14'h0002, 32'h0,         32'h1234_5678, 0, 1, 6, 32'h1234_5678, 8, 32'hA5A5_5A5A, 1'b1};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 14'h0010, 32'h0000_0011, 32'h0,        1, 0, 0, 32'h0,        3, 32'h0000_0011, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 1'b1, 14'h0020, 32'h0,         32'hCAFE_F00D, 0, 1, 3, 32'hCAFE_F00D, 4, 32'h0000_0011, 1'b0};
        vfinal  = '{1'b0, 1'b0, 1'b1, 14'h0448, 32'h0,         32'h0BAD_CAFE, 0, 1, 6, 32'h0BAD_CAFE, 8, 32'h0,         1'b0};

        for (int i = 0; i < 8; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // Write immediately followed by a held read: the read must stall
        // until IDLE and its strobe must follow a gap of low cycles.
        r_sel = 1'b0;
        r_bdo = 32'h5A5A_0001;
        @(negedge clk);
        r_write = 1'b1; r_read = 1'b0; r_addr = 14'h0100; r_wdata = 32'h0000_0001;
        waitn = 0;
        while (w_wq === 1'b1 && waitn < 50) begin
            @(negedge clk);
            waitn++;
        end
        chk("b2b accept_timeout", 32'(waitn >= 50), 32'd0);
        acc = -1; last_wr = -1; first_rd = -1; rv_at = -1; rdata = '0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (w_wr) last_wr = k;
            if (w_rd && first_rd < 0) first_rd = k;
            if (w_rv) begin
                rv_at = k;
                rdata = w_rdata;
            end
            if (k == 1) begin
                r_write = 1'b0;
                r_read  = 1'b1;
                r_addr  = 14'h0448;
            end else if (r_read) begin
                if (acc >= 0) r_read = 1'b0;
                else if (!w_wq) acc = k;
            end
        end
        chk("b2b read_accept", 32'(acc), 32'd5);
        chk("b2b last_write_cycle", 32'(last_wr), 32'd2);
        chk("b2b read_strobe", 32'(first_rd), 32'd6);
        chk("b2b gap_ok", 32'((first_rd - last_wr - 1) >= 2), 32'd1);
        chk("b2b rv_at", 32'(rv_at), 32'd11);
        chk("b2b readdata", rdata, 32'h5A5A_0001);

        // Reset during cycle T+3 of a read: no return, outputs at reset values.
        r_bdo = 32'hBBBB_0000;
        @(negedge clk);
        r_read = 1'b1; r_addr = 14'h0448;
        waitn = 0;
        while (w_wq === 1'b1 && waitn < 50) begin
            @(negedge clk);
            waitn++;
        end
        chk("abort accept_timeout", 32'(waitn >= 50), 32'd0);
        rv_n = 0;
        @(negedge clk); r_read = 1'b0;
        if (w_rv) rv_n++;
        @(negedge clk);
        if (w_rv) rv_n++;
        @(negedge clk);
        if (w_rv) rv_n++;
        rst = 1'b1;
        @(negedge clk);
        chk_reset_a("abort");
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (w_rv) rv_n++;
        end
        chk("abort no_readdatavalid", 32'(rv_n), 32'd0);

        run_vec("after_reset_read", vfinal);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
